// File: rtl/crc16_frame_check_if.sv
// Serial frame input and checker result bundle for crc16_frame_check.
// The slave side is the checker; the master side feeds bits and reads verdicts.
interface crc16_frame_check_if;
    logic        frame_start;
    logic        bit_in;
    logic        bit_valid;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [15:0] crc_calc;
    logic [15:0] crc_rx;
    logic        done;
    logic        crc_ok;
    logic        len_err;
    logic        busy;

    modport master (
        output frame_start, bit_in, bit_valid,
        input  byte_out, byte_valid, crc_calc, crc_rx, done, crc_ok, len_err, busy
    );

    modport slave (
        input  frame_start, bit_in, bit_valid,
        output byte_out, byte_valid, crc_calc, crc_rx, done, crc_ok, len_err, busy
    );
endinterface

// File: rtl/crc16_frame_check.sv
// Receive-side CRC-16 checker for a length-prefixed, MSB-first serial frame.
// Emits payload bytes and a per-frame pass/fail verdict.
module crc16_frame_check #(
    parameter logic [15:0] POLY    = 16'h8005,
    parameter logic [15:0] INIT    = 16'hFFFF,
    parameter int          MIN_LEN = 1
) (
    input  logic                 clck,
    input  logic                 start_n,
    crc16_frame_check_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CRC     = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [8:0] MIN_L = 9'(MIN_LEN);

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  len_q, len_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  byte_out_q, byte_out_d;
    logic        byte_valid_q, byte_valid_d;
    logic [15:0] crc_calc_q, crc_calc_d;
    logic [15:0] crc_rx_q, crc_rx_d;
    logic        crc_ok_q, crc_ok_d;
    logic        len_err_q, len_err_d;

    logic [7:0]  len_shift;
    logic [7:0]  sh_shift;
    logic [15:0] rx_shift;
    logic [15:0] crc_step;
    logic        last_byte;

    function automatic logic [15:0] crc_upd(input logic [15:0] r, input logic b);
        logic fb;
        fb = r[15] ^ b;
        return {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    endfunction

    assign len_shift = {len_q[6:0], bus.bit_in};
    assign sh_shift  = {shreg_q[6:0], bus.bit_in};
    assign rx_shift  = {crc_rx_q[14:0], bus.bit_in};
    assign crc_step  = crc_upd(crc_q, bus.bit_in);
    // 9-bit compare so L=255 terminates on byte 255 without counter wrap
    assign last_byte = ({1'b0, byte_cnt_q} + 9'd1) == {1'b0, len_q};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        len_d        = len_q;
        crc_d        = crc_q;
        shreg_d      = shreg_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        crc_calc_d   = crc_calc_q;
        crc_rx_d     = crc_rx_q;
        crc_ok_d     = crc_ok_q;
        len_err_d    = len_err_q;

        if (bus.frame_start) begin
            // Restart from any state; outside IDLE the same-cycle bit is the length MSB
            state_d    = LEN;
            bit_cnt_d  = 4'd0;
            byte_cnt_d = 8'd0;
            len_d      = 8'd0;
            crc_d      = INIT;
            crc_calc_d = 16'h0000;
            crc_rx_d   = 16'h0000;
            crc_ok_d   = 1'b0;
            len_err_d  = 1'b0;
            if (state_q != IDLE && bus.bit_valid) begin
                len_d     = {7'd0, bus.bit_in};
                bit_cnt_d = 4'd1;
            end
        end else begin
            unique case (state_q)
                IDLE: ;
                LEN: if (bus.bit_valid) begin
                    len_d = len_shift;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        if ({1'b0, len_shift} < MIN_L) begin
                            state_d   = IDLE;
                            len_err_d = 1'b1;
                        end else if (len_shift == 8'd0) begin
                            state_d    = CRC;
                            crc_calc_d = crc_q;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                PAYLOAD: if (bus.bit_valid) begin
                    crc_d   = crc_step;
                    shreg_d = sh_shift;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d    = 4'd0;
                        byte_out_d   = sh_shift;
                        byte_valid_d = 1'b1;
                        byte_cnt_d   = byte_cnt_q + 8'd1;
                        if (last_byte) begin
                            state_d    = CRC;
                            crc_calc_d = crc_step;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                CRC: if (bus.bit_valid) begin
                    crc_rx_d = rx_shift;
                    if (bit_cnt_q == 4'd15) begin
                        bit_cnt_d = 4'd0;
                        state_d   = DONE;
                        crc_ok_d  = (crc_calc_q == rx_shift);
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clck or negedge start_n) begin
        if (!start_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            byte_cnt_q   <= 8'd0;
            len_q        <= 8'd0;
            crc_q        <= INIT;
            shreg_q      <= 8'd0;
            byte_out_q   <= 8'd0;
            byte_valid_q <= 1'b0;
            crc_calc_q   <= 16'h0000;
            crc_rx_q     <= 16'h0000;
            crc_ok_q     <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            len_q        <= len_d;
            crc_q        <= crc_d;
            shreg_q      <= shreg_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            crc_calc_q   <= crc_calc_d;
            crc_rx_q     <= crc_rx_d;
            crc_ok_q     <= crc_ok_d;
            len_err_q    <= len_err_d;
        end
    end

    assign bus.byte_out   = byte_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.crc_calc   = crc_calc_q;
    assign bus.crc_rx     = crc_rx_q;
    assign bus.done       = (state_q == DONE);
    assign bus.crc_ok     = crc_ok_q;
    assign bus.len_err    = len_err_q;
    assign bus.busy       = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CRC);

endmodule

// File: tb/tb_crc16_frame_check.sv
// Directed bench for crc16_frame_check: frames are built from byte lists, a
// bytewise CRC model predicts the verdict, and a monitor checks every strobe.
module tb_crc16_frame_check;

    logic clck;
    logic start_n;
    crc16_frame_check_if bus();

    crc16_frame_check dut (
        .clck    (clck),
        .start_n (start_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]  payload[$];
    logic [7:0]  exp_q[$];
    int          exp_cyc_q[$];
    int          exp_done_cyc = -1;
    logic [15:0] exp_calc, exp_rx;
    logic        exp_ok;
    int          done_cnt = 0;

    initial begin
        clck = 1'b0;
        forever #5 clck = ~clck;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Bytewise CRC: XOR a byte into the high half, then eight polynomial steps
    function automatic logic [15:0] crc_model(input logic [7:0] d[$]);
        logic [15:0] r;
        r = 16'hFFFF;
        foreach (d[i]) begin
            r = r ^ {d[i], 8'h00};
            for (int k = 0; k < 8; k++)
                r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
        end
        return r;
    endfunction

    // Monitor: samples 2 time units after each rising edge
    initial begin
        forever begin
            @(posedge clck);
            cyc++;
            #2;
            if (bus.byte_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte_valid", {24'd0, bus.byte_out}, 32'hFFFF_FFFF);
                end else begin
                    chk("byte_out", {24'd0, bus.byte_out}, {24'd0, exp_q[0]});
                    chk("byte_latency", cyc, exp_cyc_q[0]);
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_latency", cyc, exp_done_cyc);
                chk("done_crc_calc", {16'd0, bus.crc_calc}, {16'd0, exp_calc});
                chk("done_crc_rx", {16'd0, bus.crc_rx}, {16'd0, exp_rx});
                chk("done_crc_ok", {31'd0, bus.crc_ok}, {31'd0, exp_ok});
                chk("done_busy", {31'd0, bus.busy}, 32'd0);
                exp_done_cyc = -1;
            end
        end
    end

    // Sends frame_start then the frame bits; stop>=0 truncates after that many bits
    task automatic send_frame(input logic [7:0] len, input logic [15:0] crc_tx,
                              input int gap, input int stop);
        logic b[$];
        int   n;
        exp_calc = crc_model(payload);
        exp_rx   = crc_tx;
        exp_ok   = (exp_calc == crc_tx);
        for (int i = 7; i >= 0; i--) b.push_back(len[i]);
        foreach (payload[j])
            for (int i = 7; i >= 0; i--) b.push_back(payload[j][i]);
        for (int i = 15; i >= 0; i--) b.push_back(crc_tx[i]);
        n = (stop < 0) ? b.size() : stop;
        @(negedge clck);
        bus.frame_start = 1'b1;
        bus.bit_valid   = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clck);
            bus.frame_start = 1'b0;
            while (gap > 0 && $urandom_range(99) < gap) begin
                bus.bit_valid = 1'b0;
                @(negedge clck);
            end
            bus.bit_valid = 1'b1;
            bus.bit_in    = b[i];
            if (i >= 8 && i < 8 + 8 * payload.size() && (i % 8) == 7) begin
                exp_q.push_back(payload[(i - 8) / 8]);
                exp_cyc_q.push_back(cyc + 1);
            end
            if (i == b.size() - 1) exp_done_cyc = cyc + 1;
        end
        @(negedge clck);
        bus.bit_valid = 1'b0;
    endtask

    task automatic load_check_string();
        payload.delete();
        for (int i = 0; i < 9; i++) payload.push_back(8'h31 + 8'(i));
    endtask

    task automatic settle_and_check(input string nm, input int done_before, input int dones);
        repeat (4) @(negedge clck);
        chk({nm, "_done_count"}, done_cnt - done_before, dones);
        chk({nm, "_bytes_drained"}, exp_q.size(), 0);
        chk({nm, "_busy_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int d0;
        logic [7:0] empty_q[$];
        bus.frame_start = 1'b0;
        bus.bit_in      = 1'b0;
        bus.bit_valid   = 1'b0;
        start_n         = 1'b0;
        repeat (3) @(negedge clck);

        // Reset state
        chk("rst_byte_out", {24'd0, bus.byte_out}, 32'd0);
        chk("rst_byte_valid", {31'd0, bus.byte_valid}, 32'd0);
        chk("rst_crc_calc", {16'd0, bus.crc_calc}, 32'd0);
        chk("rst_crc_rx", {16'd0, bus.crc_rx}, 32'd0);
        chk("rst_flags", {28'd0, bus.done, bus.crc_ok, bus.len_err, bus.busy}, 32'd0);
        start_n = 1'b1;
        repeat (2) @(negedge clck);

        // Pin the model against known check values
        load_check_string();
        chk("model_check_string", {16'd0, crc_model(payload)}, 32'h0000AEE7);
        empty_q.delete();
        chk("model_empty", {16'd0, crc_model(empty_q)}, 32'h0000FFFF);

        // 1: clean frame, contiguous bits
        d0 = done_cnt;
        send_frame(8'd9, 16'hAEE7, 0, -1);
        settle_and_check("t1", d0, 1);
        chk("t1_crc_calc_held", {16'd0, bus.crc_calc}, 32'h0000AEE7);
        chk("t1_crc_ok_held", {31'd0, bus.crc_ok}, 32'd1);

        // 2: corrupted trailer
        d0 = done_cnt;
        send_frame(8'd9, 16'hAEE6, 0, -1);
        settle_and_check("t2", d0, 1);
        chk("t2_crc_rx", {16'd0, bus.crc_rx}, 32'h0000AEE6);
        chk("t2_crc_ok", {31'd0, bus.crc_ok}, 32'd0);

        // 3: clean frame with ~50% gaps in bit_valid
        d0 = done_cnt;
        send_frame(8'd9, 16'hAEE7, 50, -1);
        settle_and_check("t3", d0, 1);
        chk("t3_crc_ok", {31'd0, bus.crc_ok}, 32'd1);

        // 4: L=0 raises len_err, then a good frame clears it
        d0 = done_cnt;
        payload.delete();
        send_frame(8'd0, 16'h0000, 0, 8);
        settle_and_check("t4_lenerr", d0, 0);
        chk("t4_len_err", {31'd0, bus.len_err}, 32'd1);
        load_check_string();
        d0 = done_cnt;
        send_frame(8'd9, 16'hAEE7, 0, -1);
        settle_and_check("t4_recover", d0, 1);
        chk("t4_len_err_cleared", {31'd0, bus.len_err}, 32'd0);
        chk("t4_crc_ok", {31'd0, bus.crc_ok}, 32'd1);

        // 5: abort partway through byte 4, then a clean frame
        d0 = done_cnt;
        payload.delete();
        for (int i = 0; i < 9; i++) payload.push_back(8'hA0 + 8'(i));
        send_frame(8'd9, 16'h1234, 0, 8 + 3 * 8 + 4);
        load_check_string();
        send_frame(8'd9, 16'hAEE7, 0, -1);
        settle_and_check("t5", d0, 1);
        chk("t5_crc_ok", {31'd0, bus.crc_ok}, 32'd1);

        // 6: reset mid-CRC
        d0 = done_cnt;
        send_frame(8'd9, 16'hAEE7, 0, 8 + 72 + 5);
        @(negedge clck);
        start_n = 1'b0;
        #1;
        chk("t6_rst_crc_calc", {16'd0, bus.crc_calc}, 32'd0);
        chk("t6_rst_crc_rx", {16'd0, bus.crc_rx}, 32'd0);
        chk("t6_rst_bytes", {23'd0, bus.byte_valid, bus.byte_out}, 32'd0);
        chk("t6_rst_flags", {28'd0, bus.done, bus.crc_ok, bus.len_err, bus.busy}, 32'd0);
        repeat (2) @(negedge clck);
        start_n = 1'b1;
        settle_and_check("t6_abort", d0, 0);
        d0 = done_cnt;
        send_frame(8'd9, 16'hAEE7, 0, -1);
        settle_and_check("t6_recover", d0, 1);
        chk("t6_crc_ok", {31'd0, bus.crc_ok}, 32'd1);

        // 7: maximum length frame, L=255
        payload.delete();
        for (int i = 0; i < 255; i++) payload.push_back(8'((i * 37 + 5) & 255));
        d0 = done_cnt;
        send_frame(8'd255, crc_model(payload), 0, -1);
        settle_and_check("t7", d0, 1);
        chk("t7_crc_ok", {31'd0, bus.crc_ok}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
